period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 137 +++++++++++++
 tb/tb_period_meter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous square wave in
// clkin cycles, with stall detection when the wave stops toggling.
module period_meter #(
  parameter int unsigned TIMEOUT = 10000000,
  parameter int unsigned CW      = 32
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          sig_in,
  input  logic          meas_en,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          stalled,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [CW-1:0]    CNT_MAX      = '1;
  localparam longint unsigned  CNT_MAX_L    = (64'd1 << CW) - 64'd1;
  // A TIMEOUT above the saturated counter value can never be reached.
  localparam bit               TO_REACHABLE = (64'(TIMEOUT) <= CNT_MAX_L);
  localparam logic [CW-1:0]    TO_CNT       = CW'(TIMEOUT);

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_sh_q, hi_sh_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          valid_q, valid_d;
  logic          stalled_q, stalled_d;

  logic          rise, fall, timeout;
  logic [CW-1:0] cnt_inc, hi_clamped;

  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign timeout    = TO_REACHABLE && (cnt_q == TO_CNT);
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign hi_clamped = (hi_sh_q < cnt_q) ? hi_sh_q : cnt_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_sh_d   = hi_sh_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;

    if (!meas_en) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      stalled_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_MEAS;
            cnt_d   = CW'(1);
            hi_sh_d = '1;
          end else if (timeout) begin
            stalled_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_MEAS: begin
          // A rise beats a simultaneous timeout; all-ones hi_sh means no fall was seen.
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hi_clamped;
            valid_d   = 1'b1;
            stalled_d = 1'b0;
            cnt_d     = CW'(1);
            hi_sh_d   = '1;
          end else if (timeout) begin
            stalled_d = 1'b1;
            state_d   = S_ARM;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
            if (fall) hi_sh_d = cnt_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_sh_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_sh_q   <= hi_sh_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign stalled   = stalled_q;
  assign busy      = (state_q == S_ARM) || (state_q == S_MEAS);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (normal timeout, tiny saturating counter)
// driven by the same waves and compared each cycle against a timestamp model.
module tb_period_meter;

  localparam int unsigned TO1 = 50;
  localparam int unsigned CW1 = 16;
  localparam int unsigned TO2 = 1000;
  localparam int unsigned CW2 = 6;

  logic           clkin = 1'b0;
  logic           rst, sig_in, meas_en;
  logic [CW1-1:0] period1, high1;
  logic           valid1, stalled1, busy1;
  logic [CW2-1:0] period2, high2;
  logic           valid2, stalled2, busy2;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int wpos   = 0;

  typedef enum {MI, MA, MM} mmode_e;
  typedef struct {
    mmode_e mode;
    longint o;
    bit     has_fall;
    longint fallc;
    longint period;
    longint high;
    bit     valid;
    bit     stalled;
  } mdl_t;

  mdl_t   mdl[2];
  longint cmax[2];
  longint tmo[2];
  bit     hist[$];

  period_meter #(.TIMEOUT(TO1), .CW(CW1)) u1 (
    .clkin(clkin), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .period(period1), .high_time(high1), .valid(valid1), .stalled(stalled1), .busy(busy1)
  );

  period_meter #(.TIMEOUT(TO2), .CW(CW2)) u2 (
    .clkin(clkin), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .period(period2), .high_time(high2), .valid(valid2), .stalled(stalled2), .busy(busy2)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic bit hbit(input int j);
    return (j < 0) ? 1'b0 : hist[j];
  endfunction

  // Timestamp model: count = edges since the origin of the current count, saturated.
  task automatic mdl_update(input int i, input bit r, input bit en, input bit rise_e, input bit fall_e);
    longint c;
    bit     to_hit;
    c = longint'(k) - mdl[i].o;
    if (c < 0) c = 0;
    if (c > cmax[i]) c = cmax[i];
    to_hit = (tmo[i] <= cmax[i]) && (c == tmo[i]);
    mdl[i].valid = 1'b0;
    if (r) begin
      mdl[i].mode = MI; mdl[i].period = 0; mdl[i].high = 0;
      mdl[i].stalled = 1'b0; mdl[i].has_fall = 1'b0;
    end else if (!en) begin
      mdl[i].mode = MI; mdl[i].stalled = 1'b0;
    end else begin
      case (mdl[i].mode)
        MI: begin mdl[i].mode = MA; mdl[i].o = longint'(k) + 1; end
        MA: begin
          if (rise_e) begin
            mdl[i].mode = MM; mdl[i].o = longint'(k); mdl[i].has_fall = 1'b0;
          end else if (to_hit) begin
            mdl[i].stalled = 1'b1; mdl[i].o = longint'(k) + 1;
          end
        end
        default: begin
          if (rise_e) begin
            mdl[i].period  = c;
            mdl[i].high    = (mdl[i].has_fall && mdl[i].fallc < c) ? mdl[i].fallc : c;
            mdl[i].valid   = 1'b1;
            mdl[i].stalled = 1'b0;
            mdl[i].o = longint'(k); mdl[i].has_fall = 1'b0;
          end else if (to_hit) begin
            mdl[i].stalled = 1'b1; mdl[i].mode = MA; mdl[i].o = longint'(k) + 1;
          end else if (fall_e) begin
            mdl[i].has_fall = 1'b1; mdl[i].fallc = c;
          end
        end
      endcase
    end
  endtask

  task automatic cmp(input int i, input logic [63:0] p, input logic [63:0] h,
                     input logic v, input logic s, input logic b);
    check($sformatf("u%0d.valid", i + 1),   64'(v), 64'(mdl[i].valid));
    check($sformatf("u%0d.stalled", i + 1), 64'(s), 64'(mdl[i].stalled));
    check($sformatf("u%0d.busy", i + 1),    64'(b), 64'(mdl[i].mode != MI));
    check($sformatf("u%0d.period", i + 1),  p, 64'(mdl[i].period));
    check($sformatf("u%0d.high", i + 1),    h, 64'(mdl[i].high));
  endtask

  task automatic step(input bit r, input bit en, input bit s);
    bit rise_e, fall_e;
    rst = r; meas_en = en; sig_in = s;
    @(posedge clkin);
    #1;
    rise_e = hbit(k - 2) && !hbit(k - 3);
    fall_e = !hbit(k - 2) && hbit(k - 3);
    hist.push_back(r ? 1'b0 : s);
    // The reset clears the whole synchronizer, not only the first stage.
    if (r && k >= 1) hist[k - 1] = 1'b0;
    if (r && k >= 2) hist[k - 2] = 1'b0;
    for (int i = 0; i < 2; i++) mdl_update(i, r, en, rise_e, fall_e);
    cmp(0, 64'(period1), 64'(high1), valid1, stalled1, busy1);
    cmp(1, 64'(period2), 64'(high2), valid2, stalled2, busy2);
    k++;
  endtask

  function automatic bit wv(input int hi, input int lo);
    bit v;
    v = (wpos % (hi + lo)) < hi;
    wpos++;
    return v;
  endfunction

  task automatic wave(input int hi, input int lo, input int n);
    wpos = 0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, wv(hi, lo));
  endtask

  initial begin
    longint saved;
    bit     found;
    cmax[0] = (64'd1 << CW1) - 1; tmo[0] = TO1;
    cmax[1] = (64'd1 << CW2) - 1; tmo[1] = TO2;
    for (int i = 0; i < 2; i++) begin
      mdl[i].mode = MI; mdl[i].o = 0; mdl[i].has_fall = 1'b0; mdl[i].fallc = 0;
      mdl[i].period = 0; mdl[i].high = 0; mdl[i].valid = 1'b0; mdl[i].stalled = 1'b0;
    end

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check("rst_period", 64'(period1), 64'd0);
    check("rst_busy",   64'(busy1),   64'd0);

    wave(5, 5, 60);
    check("w55_period", 64'(period1), 64'd10);
    check("w55_high",   64'(high1),   64'd5);

    wave(3, 7, 50);
    check("w37_period", 64'(period1), 64'd10);
    check("w37_high",   64'(high1),   64'd3);
    wave(2, 2, 20);
    check("w22_period", 64'(period1), 64'd4);
    check("w22_high",   64'(high1),   64'd2);

    for (int i = 0; i < 120; i++) step(1'b0, 1'b1, 1'b0);
    check("stall_u1", 64'(stalled1), 64'd1);
    check("stall_u2", 64'(stalled2), 64'd0);
    wave(5, 5, 40);
    check("unstall_u1", 64'(stalled1), 64'd0);

    wave(40, 40, 240);
    check("sat_period", 64'(period2), 64'd63);
    check("sat_high",   64'(high2),   64'd40);

    wpos = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b1, wv(5, 5));
      found = mdl[0].valid;
    end
    check("rst_mid_found", 64'(found), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, wv(5, 5));
    step(1'b1, 1'b1, wv(5, 5));
    check("rst_mid_period", 64'(period1), 64'd0);
    check("rst_mid_high",   64'(high1),   64'd0);
    check("rst_mid_busy",   64'(busy1),   64'd0);
    wave(5, 5, 40);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (hbit(k - 2) && !hbit(k - 3) && mdl[0].mode == MM) found = 1'b1;
      else step(1'b0, 1'b1, wv(5, 5));
    end
    check("drop_found", 64'(found), 64'd1);
    saved = mdl[0].period;
    step(1'b0, 1'b0, wv(5, 5));
    check("drop_busy",   64'(busy1),   64'd0);
    check("drop_valid",  64'(valid1),  64'd0);
    check("drop_period", 64'(period1), 64'(saved));
    check("drop_const",  64'(period1), 64'd10);

    for (int seg = 0; seg < 40; seg++) begin
      int hi, lo, n;
      hi = int'($urandom_range(1, 12));
      lo = int'($urandom_range(1, 12));
      n  = int'($urandom_range(10, 50));
      wpos = 0;
      for (int i = 0; i < n; i++)
        step($urandom_range(0, 99) == 0, $urandom_range(0, 99) >= 4, wv(hi, lo));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
